// File: rtl/core_pkg.sv
// Shared definitions for the instruction sequencer and the core it drives.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: sequencer state encoding, instruction format codes, field positions
// and a helper that extracts the format field from a 16-bit instruction.
package core_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WAIT   = 3'd4,
        S_BRANCH = 3'd5,
        S_HALT   = 3'd6,
        S_ERROR  = 3'd7
    } state_t;

    // Instruction format codes held in the low two bits of every instruction.
    localparam logic [1:0] FMT_REG  = 2'd0;
    localparam logic [1:0] FMT_IMM  = 2'd1;
    localparam logic [1:0] FMT_BR   = 2'd2;
    localparam logic [1:0] FMT_HALT = 2'd3;

    // Field positions.
    localparam int FMT_LSB = 0;
    localparam int FMT_MSB = 1;
    localparam int TGT_LSB = 5;
    localparam int TGT_MSB = 12;

    function automatic logic [1:0] instr_fmt(input logic [15:0] instr);
        return instr[FMT_MSB:FMT_LSB];
    endfunction

endpackage

// File: rtl/wait_timer.sv
// Cycle counter bounding how long the sequencer waits for the core.
// Latency: expired is decoded from the count register (no input-to-output path).
// Backpressure: none; counts while enable is high, holds at the limit.
// Ports: clk/rst (async active-high), clear (zero the count), enable (count one
// cycle), expired (high during the TIMEOUT-th enabled cycle after a clear).
module wait_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    // The count reads k-1 during the k-th enabled cycle, so it only needs to
    // reach TIMEOUT-1; it parks there rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = (cnt == LIMIT);

endmodule

// File: rtl/core_sequencer.sv
// Fetches 16-bit instructions, issues ALU ops to the core and resolves branches.
// Latency: 4 cycles per ALU op (1-cycle memory, done 1 cycle after run), 3 per branch.
// Backpressure: FETCH holds imem_req until imem_valid; WAIT holds until core_done or timeout.
// Ports: start/start_pc launch a program; imem_* is the fetch port; core_* and
// branch/branch_res talk to the core; pc/busy/halted/err/instr_count are status.
module core_sequencer
    import core_pkg::*;
#(
    parameter int PC_W    = 8,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [PC_W-1:0] start_pc,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [15:0]     imem_data,
    output logic [15:0]     core_instruction,
    output logic            core_run,
    input  logic            core_done,
    input  logic            branch_res,
    output logic            branch,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            halted,
    output logic            err,
    output logic [15:0]     instr_count
);

    state_t          state;
    state_t          state_nxt;
    logic [15:0]     instr_q;
    logic [PC_W-1:0] pc_q;
    logic [15:0]     count_q;
    logic [15:0]     count_inc;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] target;
    logic [1:0]      fmt;
    logic            timer_expired;

    assign fmt       = instr_fmt(instr_q);
    // Size cast both truncates and zero-extends, whatever PC_W is.
    assign target    = PC_W'(instr_q[TGT_MSB:TGT_LSB]);
    assign pc_inc    = pc_q + PC_W'(1);
    assign count_inc = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;

    // Counter is zeroed in EXEC so it reads 0 on the first WAIT cycle.
    wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (reset),
        .clear   (state == S_EXEC),
        .enable  (state == S_WAIT),
        .expired (timer_expired)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_HALT, S_ERROR: begin
                if (start) begin
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                if (imem_valid) begin
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                case (fmt)
                    FMT_REG, FMT_IMM: state_nxt = S_EXEC;
                    FMT_BR:           state_nxt = S_BRANCH;
                    FMT_HALT:         state_nxt = S_HALT;
                    default:          state_nxt = S_HALT;
                endcase
            end
            S_EXEC: begin
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // A done arriving on the last allowed cycle still counts.
                if (core_done) begin
                    state_nxt = S_FETCH;
                end else if (timer_expired) begin
                    state_nxt = S_ERROR;
                end
            end
            S_BRANCH: begin
                state_nxt = S_FETCH;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // PC, instruction register and retired-instruction count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= '0;
            instr_q <= 16'h0000;
            count_q <= 16'h0000;
        end else begin
            case (state)
                S_IDLE, S_HALT, S_ERROR: begin
                    if (start) begin
                        pc_q    <= start_pc;
                        count_q <= 16'h0000;
                    end
                end
                S_FETCH: begin
                    if (imem_valid) begin
                        instr_q <= imem_data;
                    end
                end
                S_WAIT: begin
                    if (core_done) begin
                        pc_q    <= pc_inc;
                        count_q <= count_inc;
                    end
                end
                S_BRANCH: begin
                    pc_q    <= branch_res ? target : pc_inc;
                    count_q <= count_inc;
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs: decoded from state and registers only.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = '0;
        core_run  = 1'b0;
        branch    = 1'b0;
        busy      = 1'b1;
        halted    = 1'b0;
        err       = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
            end
            S_FETCH: begin
                imem_req  = 1'b1;
                imem_addr = pc_q;
            end
            S_DECODE, S_BRANCH: begin
                branch = (fmt == FMT_BR);
            end
            S_EXEC: begin
                core_run = 1'b1;
            end
            S_HALT: begin
                busy   = 1'b0;
                halted = 1'b1;
            end
            S_ERROR: begin
                busy = 1'b0;
                err  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign core_instruction = instr_q;
    assign pc               = pc_q;
    assign instr_count      = count_q;

endmodule

// File: tb/tb_core_sequencer.sv
module tb_core_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  start_pc;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_valid;
    logic [15:0] imem_data;
    logic [15:0] core_instruction;
    logic        core_run;
    logic        core_done;
    logic        branch_res;
    logic        branch;
    logic [7:0]  pc;
    logic        busy;
    logic        halted;
    logic        err;
    logic [15:0] instr_count;

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] mem [256];
    logic [15:0] exp_run[$];
    logic [7:0]  exp_fetch[$];
    int          run_times[$];
    int          run_cnt   = 0;
    int          cyc       = 0;
    bit          prev_req  = 1'b0;
    int          mem_lat   = 0;
    int          done_lat  = 1;
    int          stall_ctr = 0;
    int          done_cnt  = 0;

    core_sequencer #(
        .PC_W    (8),
        .TIMEOUT (64)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .start_pc         (start_pc),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_valid       (imem_valid),
        .imem_data        (imem_data),
        .core_instruction (core_instruction),
        .core_run         (core_run),
        .core_done        (core_done),
        .branch_res       (branch_res),
        .branch           (branch),
        .pc               (pc),
        .busy             (busy),
        .halted           (halted),
        .err              (err),
        .instr_count      (instr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        vectors++;
        assert (obs === want) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // Memory and core responders, driven on the falling edge.
    always @(negedge clk) begin
        core_done = 1'b0;
        if (reset) begin
            done_cnt = 0;
        end else begin
            if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) core_done = 1'b1;
            end
            if (core_run && done_lat > 0) done_cnt = done_lat;
        end
        if (imem_req) begin
            if (stall_ctr >= mem_lat) begin
                imem_valid = 1'b1;
                imem_data  = mem[imem_addr];
            end
            stall_ctr++;
        end else begin
            imem_valid = 1'b0;
            stall_ctr  = 0;
        end
    end

    // Scoreboard monitor: issued instructions and fetch addresses.
    always @(negedge clk) begin
        cyc++;
        if (core_run) begin
            run_cnt++;
            run_times.push_back(cyc);
            chk("run_expected", 32'(exp_run.size() != 0), 32'd1);
            if (exp_run.size() != 0) chk("run_instr", 32'(core_instruction), 32'(exp_run.pop_front()));
        end
        if (imem_req && !prev_req) begin
            chk("fetch_expected", 32'(exp_fetch.size() != 0), 32'd1);
            if (exp_fetch.size() != 0) chk("fetch_addr", 32'(imem_addr), 32'(exp_fetch.pop_front()));
        end
        prev_req = imem_req;
    end

    task automatic pulse_start(input logic [7:0] a);
        start_pc = a;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int n = 0;
        while (!(halted || err) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(halted || err), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; start_pc = 8'h00; branch_res = 1'b0;
        core_done = 1'b0; imem_valid = 1'b0; imem_data = 16'h0000;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0003;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_imem_addr", 32'(imem_addr), 32'd0);
        chk("rst_core_run", 32'(core_run), 32'd0);
        chk("rst_branch", 32'(branch), 32'd0);
        chk("rst_instr", 32'(core_instruction), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_status", 32'({busy, halted, err}), 32'd0);
        chk("rst_count", 32'(instr_count), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Straight line: ALU, ALU-imm, halt
        mem[0] = 16'h0004; mem[1] = 16'h0011; mem[2] = 16'h0003;
        exp_run.push_back(16'h0004); exp_run.push_back(16'h0011);
        exp_fetch.push_back(8'h00); exp_fetch.push_back(8'h01); exp_fetch.push_back(8'h02);
        run_cnt = 0; run_times.delete();
        pulse_start(8'h00);
        wait_end("sl_end");
        chk("sl_halted", 32'(halted), 32'd1);
        chk("sl_pc", 32'(pc), 32'd2);
        chk("sl_count", 32'(instr_count), 32'd2);
        chk("sl_runs", 32'(run_cnt), 32'd2);
        if (run_times.size() >= 2) chk("sl_cycles_per_instr", 32'(run_times[1] - run_times[0]), 32'd4);

        // Branch taken: pc 5 -> 0x20
        mem[5] = 16'h0402; mem[8'h20] = 16'h0003; mem[6] = 16'h0003;
        branch_res = 1'b1;
        exp_fetch.push_back(8'h05); exp_fetch.push_back(8'h20);
        run_cnt = 0;
        pulse_start(8'h05);
        chk("br_fetch_branch", 32'(branch), 32'd0);
        @(negedge clk);
        chk("br_decode_branch", 32'(branch), 32'd1);
        chk("br_decode_instr", 32'(core_instruction), 32'h0402);
        @(negedge clk);
        chk("br_branch_state", 32'(branch), 32'd1);
        chk("br_branch_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("br_next_addr", 32'(imem_addr), 32'h20);
        chk("br_next_branch", 32'(branch), 32'd0);
        wait_end("brt_end");
        chk("brt_pc", 32'(pc), 32'h20);
        chk("brt_count", 32'(instr_count), 32'd1);

        // Branch not taken: pc 5 -> 6
        branch_res = 1'b0;
        exp_fetch.push_back(8'h05); exp_fetch.push_back(8'h06);
        pulse_start(8'h05);
        wait_end("brn_end");
        chk("brn_pc", 32'(pc), 32'h06);
        chk("brn_count", 32'(instr_count), 32'd1);
        chk("br_no_run", 32'(run_cnt), 32'd0);

        // Timeout: done never arrives
        mem[8'h10] = 16'h0004; mem[8'h11] = 16'h0003;
        done_lat = 0;
        exp_run.push_back(16'h0004); exp_fetch.push_back(8'h10);
        pulse_start(8'h10);
        n = 0;
        while (!core_run && n < 10) begin @(negedge clk); n++; end
        chk("to_run_seen", 32'(core_run), 32'd1);
        n = 0;
        while (!err && n < 200) begin
            @(negedge clk);
            if (!err) n++;
        end
        chk("to_wait_cycles", 32'(n), 32'd64);
        chk("to_err", 32'(err), 32'd1);
        chk("to_busy", 32'(busy), 32'd0);

        // start clears err and refetches
        done_lat = 1;
        exp_run.push_back(16'h0004); exp_fetch.push_back(8'h10); exp_fetch.push_back(8'h11);
        pulse_start(8'h10);
        chk("to_err_cleared", 32'(err), 32'd0);
        chk("to_refetch_addr", 32'(imem_addr), 32'h10);
        wait_end("to_restart_end");
        chk("to_restart_halted", 32'(halted), 32'd1);
        chk("to_restart_pc", 32'(pc), 32'h11);

        // done on the 64th WAIT cycle wins
        done_lat = 64;
        exp_run.push_back(16'h0004); exp_fetch.push_back(8'h10); exp_fetch.push_back(8'h11);
        pulse_start(8'h10);
        wait_end("to_edge_end");
        chk("to_edge_err", 32'(err), 32'd0);
        chk("to_edge_count", 32'(instr_count), 32'd1);

        // Wrap and stall
        done_lat = 1; mem_lat = 2;
        mem[8'hFF] = 16'h0004; mem[0] = 16'h0003;
        exp_run.push_back(16'h0004); exp_fetch.push_back(8'hFF); exp_fetch.push_back(8'h00);
        pulse_start(8'hFF);
        n = 0;
        while (imem_req && n < 10) begin
            chk("ws_addr_steady", 32'(imem_addr), 32'hFF);
            n++;
            @(negedge clk);
        end
        chk("ws_req_cycles", 32'(n), 32'd3);
        wait_end("ws_end");
        chk("ws_pc_wrapped", 32'(pc), 32'h00);
        chk("ws_count", 32'(instr_count), 32'd1);

        // Reset mid-WAIT
        mem_lat = 0; done_lat = 0;
        mem[8'h40] = 16'h0004;
        exp_run.push_back(16'h0004); exp_fetch.push_back(8'h40);
        pulse_start(8'h40);
        n = 0;
        while (!core_run && n < 10) begin @(negedge clk); n++; end
        @(negedge clk);
        chk("rw_in_wait", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rw_async_outs", 32'({imem_req, core_run, branch, busy, halted, err}), 32'd0);
        chk("rw_async_pc", 32'(pc), 32'd0);
        chk("rw_async_instr", 32'(core_instruction), 32'd0);
        chk("rw_async_count", 32'(instr_count), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rw_idle", 32'({busy, halted, err, imem_req}), 32'd0);

        // start during FETCH is ignored
        mem_lat = 3; mem[8'h50] = 16'h0003;
        exp_fetch.push_back(8'h50);
        pulse_start(8'h50);
        start_pc = 8'h60;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        chk("ig_pc", 32'(pc), 32'h50);
        chk("ig_addr", 32'(imem_addr), 32'h50);
        wait_end("ig_end");
        chk("ig_halt_pc", 32'(pc), 32'h50);
        chk("ig_count", 32'(instr_count), 32'd0);

        chk("sb_run_drained", 32'(exp_run.size()), 32'd0);
        chk("sb_fetch_drained", 32'(exp_fetch.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Instruction sequencer that drives the processor core. It fetches 16-bit instructions from an instruction memory port and issues each one to the core with a one-cycle `run` pulse, then waits for `done`. It resolves branches using the core's `branch_res` flag and stops on a halt instruction or a `done` timeout. It sits between the instruction memory and the core, and replaces the testbench that hand-feeds `instruction`/`run` today.

## Interface
- `PC_W`, 8, program-counter / instruction-address width
- `TIMEOUT`, 64, maximum cycles in WAIT before error (≥2)
- `clk` in 1: single clock, all state on posedge
- `reset` in 1: asynchronous, active-high; clears all state
- `start` in 1: begin execution at `start_pc`; sampled only in IDLE, HALT, ERROR
- `start_pc` in PC_W: initial PC, captured with `start`
- `imem_req` out 1: fetch request, held until `imem_valid`
- `imem_addr` out PC_W: equals `pc` while `imem_req`
- `imem_valid` in 1: `imem_data` valid; ignored when `imem_req`=0
- `imem_data` in 16: fetched instruction
- `core_instruction` out 16: latched instruction, stable from DECODE until next DECODE
- `core_run` out 1: one-cycle issue pulse
- `core_done` in 1: core finished current instruction
- `branch_res` in 1: branch condition from core
- `branch` out 1: high in DECODE/BRANCH for branch instructions (core suppresses writeback)
- `pc` out PC_W: current program counter
- `busy` out 1: state ∉ {IDLE, HALT, ERROR}
- `halted` out 1: state == HALT
- `err` out 1: state == ERROR
- `instr_count` out 16: retired instructions (ALU + branch), saturating at 16'hFFFF

## Operation
- Decode fields (shared with core): `[1:0]` format. 0 = register ALU op, 1 = immediate ALU op, 2 = branch, 3 = halt. Branch target = `instr[12:5]`, truncated or zero-extended to PC_W.
- States: IDLE, FETCH, DECODE, EXEC, WAIT, BRANCH, HALT, ERROR.
- IDLE/HALT/ERROR + `start` → FETCH. Load `pc`←`start_pc`, clear `instr_count`. In ERROR, `start` also clears `err`.
- FETCH: `imem_req`=1. On `imem_valid`, latch `imem_data` into the instruction register → DECODE.
- DECODE (1 cycle):
  - format 3 → HALT; pc unchanged.
  - format 2 → BRANCH.
  - format 0/1 → EXEC.
- EXEC (1 cycle): `core_run`=1 → WAIT.
- WAIT: on `core_done` → pc←pc+1, count+1 → FETCH.
  - Cycle counter reset on WAIT entry. Reaching TIMEOUT cycles without `core_done` → ERROR.
- BRANCH (1 cycle): sample `branch_res`; pc ← `branch_res` ? target : pc+1; count+1 → FETCH.
- PC arithmetic is modulo 2^PC_W: pc+1 from all-ones wraps to 0.
- `core_done` outside WAIT is ignored.
- `start` while busy is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, `core_instruction`=16'h0000.
- Best-case ALU instruction with 1-cycle memory and `done` one cycle after `run`: FETCH(1) + DECODE(1) + EXEC(1) + WAIT(1) = 4 cycles per instruction.
- Branch: FETCH + DECODE + BRANCH = 3 cycles. Taken and not-taken cost the same.
- `imem_valid` in the same cycle `imem_req` rises is accepted (zero-wait memory allowed).
- `core_done` coincident with the TIMEOUT-th cycle: `done` wins, no error.
- `reset` mid-operation forces IDLE asynchronously.
  - `core_run` and `imem_req` drop the same cycle.
  - An outstanding `imem_valid` arriving after reset is ignored.
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.

## Structure
- Package `core_pkg`:
  - `state_t` enum
  - format constants `FMT_REG`=0, `FMT_IMM`=1, `FMT_BR`=2, `FMT_HALT`=3
  - field-position localparams (format, target)
- Sub-module `wait_timer`: counter with clear/enable and a `expired` output at TIMEOUT. This is the only natural split; the FSM, PC and count stay in `core_sequencer`.

## Test plan
- Straight line:
  - Stimulus: `start_pc`=0; memory {16'h0004 (fmt0), 16'h0011 (fmt1), 16'h0003 (halt)}; 1-cycle memory; `done` 1 cycle after `run`.
  - Required: exactly 2 `core_run` pulses, `halted`=1 with `pc`=2, `instr_count`=2, 4 cycles/instr.
- Branch:
  - Stimulus: instr at pc 5 = target 8'h20, format 2.
  - Required: with `branch_res`=1, next `imem_addr`=8'h20; with `branch_res`=0, next `imem_addr`=6. `branch`=1 only in DECODE/BRANCH, and no `core_run` is issued.
- Timeout:
  - Stimulus: hold `core_done`=0 after an ALU issue, TIMEOUT=64.
  - Required: `err`=1 after exactly 64 WAIT cycles. `start` then clears `err` and refetches from `start_pc`.
  - Edge: `done` on cycle 64 → no error.
- Wrap and stall:
  - Stimulus: `start_pc`=8'hFF, ALU op, `imem_valid` delayed 3 cycles.
  - Required: `imem_req` held 3 cycles, `imem_addr` steady, next fetch at 8'h00.
- Reset mid-WAIT and ignored start:
  - Stimulus: assert `reset` in WAIT.
  - Required: all outputs 0 asynchronously, then IDLE. A `start` pulse during FETCH is ignored (pc unchanged).
